// File: rtl/alu_div_unit.sv
// alu_div_unit: iterative restoring radix-2 divider giving div/rem beside the ALU
module alu_div_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] DIV0_QUOT = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             Sign,
  input  logic             RemSel,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             div0
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t           r_state;
  logic             r_busy, r_done, r_div0, r_rem_sel, r_qneg, r_rneg;
  logic [WIDTH-1:0] r_out, r_rem, r_quo, r_dvs;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_a, w_b, w_rem_n, w_quo_n, w_res;
  assign w_a     = (Sign & in1[WIDTH-1]) ? -in1 : in1;
  assign w_b     = (Sign & in2[WIDTH-1]) ? -in2 : in2;
  assign w_sh    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = w_sh >= {1'b0, r_dvs};
  // when the trial succeeds the difference is below the divisor, so the low WIDTH bits suffice
  assign w_rem_n = w_ge ? w_sh[WIDTH-1:0] - r_dvs : w_sh[WIDTH-1:0];
  assign w_quo_n = {r_quo[WIDTH-2:0], w_ge};
  assign w_res   = r_rem_sel ? (r_rneg ? -w_rem_n : w_rem_n) : (r_qneg ? -w_quo_n : w_quo_n);
  assign busy    = r_busy;
  assign done    = r_done;
  assign out     = r_out;
  assign div0    = r_div0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_div0    <= 1'b0;
      r_out     <= '0;
      r_rem_sel <= 1'b0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_busy    <= 1'b1;
          r_rem_sel <= RemSel;
          r_qneg    <= Sign & (in1[WIDTH-1] ^ in2[WIDTH-1]);
          r_rneg    <= Sign & in1[WIDTH-1];
          r_rem     <= '0;
          r_quo     <= w_a;
          r_dvs     <= w_b;
          r_cnt     <= CW'(WIDTH);
          if (in2 == '0) begin
            r_state <= FIN;
            r_done  <= 1'b1;
            r_div0  <= 1'b1;
            r_out   <= RemSel ? in1 : DIV0_QUOT;
          end else begin
            r_state <= CALC;
          end
        end
        CALC: begin
          r_rem <= w_rem_n;
          r_quo <= w_quo_n;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= FIN;
            r_done  <= 1'b1;
            r_div0  <= 1'b0;
            r_out   <= w_res;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_div_unit.sv
// tb_alu_div_unit: directed + small random scoreboard bench for the iterative divider
module tb_alu_div_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, Sign = 1'b0, RemSel = 1'b0;
  logic [31:0] in1 = '0, in2 = '0, out;
  logic        busy, done, div0;
  logic [32:0] q_exp[$];
  int          n_vec = 0, n_err = 0;
  alu_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .Sign(Sign), .RemSel(RemSel),
    .in1(in1), .in2(in2), .busy(busy), .done(done), .out(out), .div0(div0)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [32:0] model(input bit s, input bit r, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return {1'b1, r ? a : 32'hFFFF_FFFF};
    if (s) return {1'b0, r ? 32'(sa % sb) : 32'(sa / sb)};
    return {1'b0, r ? a % b : a / b};
  endfunction
  task automatic start_op(input bit s, input bit r, input logic [31:0] a, input logic [31:0] b, input logic [32:0] e);
    Sign = s; RemSel = r; in1 = a; in2 = b; start = 1'b1;
    q_exp.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    in1 = $urandom; in2 = $urandom; Sign = ~s; RemSel = ~r;
  endtask
  task automatic finish_op(input string tag, input int exp_lat);
    int lat = 1;
    logic [32:0] e;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    e = (q_exp.size() != 0) ? q_exp.pop_front() : 'x;
    chk({tag, "_out"}, 64'({div0, out}), 64'(e));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'({busy, done}), 64'd0);
  endtask
  initial begin
    bit seen;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_state", 64'({busy, done, div0, out}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_state", 64'({busy, done, div0, out}), 64'd0);
    start_op(0, 0, 100, 7, {1'b0, 32'd14});                  finish_op("u100div7", 33);
    start_op(0, 1, 100, 7, {1'b0, 32'd2});                   finish_op("u100rem7", 33);
    start_op(1, 0, 32'hFFFF_FFF9, 2, {1'b0, 32'hFFFF_FFFD}); finish_op("sm7div2", 33);
    start_op(1, 1, 32'hFFFF_FFF9, 2, {1'b0, 32'hFFFF_FFFF}); finish_op("sm7rem2", 33);
    start_op(1, 0, 7, 32'hFFFF_FFFE, {1'b0, 32'hFFFF_FFFD}); finish_op("s7divm2", 33);
    start_op(1, 1, 7, 32'hFFFF_FFFE, {1'b0, 32'd1});         finish_op("s7remm2", 33);
    start_op(0, 0, 32'h1234, 0, {1'b1, 32'hFFFF_FFFF});      finish_op("div0_quo", 1);
    start_op(1, 1, 32'h1234, 0, {1'b1, 32'h1234});           finish_op("div0_rem", 1);
    start_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h8000_0000}); finish_op("ovf_squo", 33);
    start_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'd0});         finish_op("ovf_srem", 33);
    start_op(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'd0});         finish_op("ovf_uquo", 33);
    start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h8000_0000}); finish_op("ovf_urem", 33);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      bit s, r;
      s = i[0]; r = i[1];
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if (b == 0 || b == 32'hFFFF_FFFF) b = 32'd5;
      start_op(s, r, a, b, model(s, r, a, b));
      finish_op("rand", 33);
    end
    // start held high across a whole op; operands change mid-calculation
    Sign = 0; RemSel = 0; in1 = 100; in2 = 7; start = 1'b1;
    q_exp.push_back({1'b0, 32'd14});
    @(posedge clk); #1;
    in1 = 50; in2 = 3;
    q_exp.push_back({1'b0, 32'd16});
    finish_op("held1", 33);
    @(posedge clk); #1;
    chk("held_reaccept", 64'(busy), 64'd1);
    start = 1'b0;
    in1 = 0; in2 = 0;
    finish_op("held2", 33);
    // asynchronous reset in cycle 10 of a calculation
    start_op(0, 0, 1000, 3, {1'b0, 32'd333});
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_state", 64'({busy, done, div0, out}), 64'd0);
    void'(q_exp.pop_back());
    @(posedge clk); #1 reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= done | busy;
    end
    chk("abort_nodone", 64'(seen), 64'd0);
    start_op(0, 0, 9, 3, {1'b0, 32'd3}); finish_op("fresh9div3", 33);
    chk("sb_empty", 64'(q_exp.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
